pl_ctrl_unit: RTL

Decode/hazard controller for the pipelined RV32I core. It sits in the ID stage.
- Decodes the ID-stage instruction into the immediate-select code for the immediate extender, plus datapath controls.
- Registers those controls into the ID/EX stage.
- Detects load-use hazards and generates stall and flush for the IF/ID and ID/EX stages.

---
 rtl/pl_pkg.sv | 54 +++++
 rtl/pl_decoder.sv | 87 ++++++++
 rtl/pl_ctrl_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/pl_pkg.sv
// Shared decode types for the pipelined RV32I control unit: opcodes,
// immediate/writeback select encodings and the ID/EX control bundle.
package pl_pkg;

  localparam int PL_X_LEN      = 32;
  localparam int PL_REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic [PL_REG_ADDR_W-1:0] rd;
    logic                     reg_wr;
    logic                     mem_rd;
    logic                     mem_wr;
    logic                     branch;
    logic                     jump;
    wb_sel_e                  wb_sel;
    logic                     alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    rd:      '0,
    reg_wr:  1'b0,
    mem_rd:  1'b0,
    mem_wr:  1'b0,
    branch:  1'b0,
    jump:    1'b0,
    wb_sel:  WB_ALU,
    alu_src: 1'b0
  };

endpackage

// File: rtl/pl_decoder.sv
// Combinational RV32I opcode decoder: datapath controls, immediate select,
// illegal-opcode flag and which source registers the instruction reads.
module pl_decoder
  import pl_pkg::*;
(
  input  logic [6:0]               i_opcode,
  input  logic [PL_REG_ADDR_W-1:0] i_rd,
  output ctrl_t                    o_ctrl,
  output imm_sel_e                 o_imm_sel,
  output logic                     o_illegal,
  output logic                     o_use_rs1,
  output logic                     o_use_rs2
);

  logic w_writes_rd;

  always_comb begin
    o_ctrl      = CTRL_BUBBLE;
    o_imm_sel   = IMM_I;
    o_illegal   = 1'b0;
    o_use_rs1   = 1'b1;
    o_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;

    unique case (i_opcode)
      OPC_LUI, OPC_AUIPC: begin
        o_imm_sel      = IMM_U;
        o_use_rs1      = 1'b0;
        w_writes_rd    = 1'b1;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_JAL: begin
        o_imm_sel      = IMM_J;
        o_use_rs1      = 1'b0;
        w_writes_rd    = 1'b1;
        o_ctrl.jump    = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_JALR: begin
        o_imm_sel      = IMM_I;
        w_writes_rd    = 1'b1;
        o_ctrl.jump    = 1'b1;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm_sel      = IMM_B;
        o_use_rs2      = 1'b1;
        o_ctrl.branch  = 1'b1;
      end
      OPC_LOAD: begin
        o_imm_sel      = IMM_I;
        w_writes_rd    = 1'b1;
        o_ctrl.mem_rd  = 1'b1;
        o_ctrl.wb_sel  = WB_MEM;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_STORE: begin
        o_imm_sel      = IMM_S;
        o_use_rs2      = 1'b1;
        o_ctrl.mem_wr  = 1'b1;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_OPIMM: begin
        o_imm_sel      = IMM_I;
        w_writes_rd    = 1'b1;
        o_ctrl.alu_src = 1'b1;
      end
      OPC_OP: begin
        o_imm_sel      = IMM_I;
        o_use_rs2      = 1'b1;
        w_writes_rd    = 1'b1;
      end
      default: begin
        o_illegal      = 1'b1;
      end
    endcase

    // rd only carries meaning for writers; S/B reuse those bits as immediate
    if (w_writes_rd) begin
      o_ctrl.rd     = i_rd;
      o_ctrl.reg_wr = (i_rd != '0);
    end
  end

endmodule

// File: rtl/pl_ctrl_unit.sv
// ID-stage decode/hazard controller: decodes the IF/ID instruction, registers
// its controls into ID/EX and raises load-use stall or branch flush.
module pl_ctrl_unit
  import pl_pkg::*;
#(
  parameter int X_LEN      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [X_LEN-1:0]      instr_i,
  input  logic                  id_valid_i,
  input  logic                  br_taken_i,
  output logic [2:0]            imm_sel_o,
  output logic                  illegal_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  ex_valid_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_reg_wr_o,
  output logic                  ex_mem_rd_o,
  output logic                  ex_mem_wr_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic [1:0]            ex_wb_sel_o,
  output logic                  ex_alu_src_o,
  output logic [15:0]           stall_cnt_o
);

  ctrl_t    w_dec_ctrl;
  imm_sel_e w_imm_sel;
  logic     w_illegal;
  logic     w_use_rs1;
  logic     w_use_rs2;
  logic     w_rs1_hit;
  logic     w_rs2_hit;
  logic     w_hazard;
  logic     w_stall;
  logic     w_flush;
  logic     w_bubble;
  logic     w_unused_bits;

  ctrl_t       r_ex;
  logic        r_ex_valid;
  logic [15:0] r_stall_cnt;

  pl_decoder u_decoder (
    .i_opcode  (instr_i[6:0]),
    .i_rd      (instr_i[11:7]),
    .o_ctrl    (w_dec_ctrl),
    .o_imm_sel (w_imm_sel),
    .o_illegal (w_illegal),
    .o_use_rs1 (w_use_rs1),
    .o_use_rs2 (w_use_rs2)
  );

  // funct3/funct7 only matter to the ALU decoder further down the pipe
  assign w_unused_bits = ^{instr_i[X_LEN-1:25], instr_i[14:12]};

  assign w_rs1_hit = w_use_rs1 && (instr_i[19:15] == r_ex.rd);
  assign w_rs2_hit = w_use_rs2 && (instr_i[24:20] == r_ex.rd);
  assign w_hazard  = r_ex_valid && r_ex.mem_rd && (r_ex.rd != '0) &&
                     id_valid_i && (w_rs1_hit || w_rs2_hit);

  // A taken branch squashes the consumer anyway, so it overrides the stall
  assign w_flush  = br_taken_i;
  assign w_stall  = w_hazard && !w_flush;
  assign w_bubble = w_flush || w_stall || !id_valid_i || w_illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ex_valid <= 1'b0;
      r_ex       <= CTRL_BUBBLE;
    end else if (w_bubble) begin
      r_ex_valid <= 1'b0;
      r_ex       <= CTRL_BUBBLE;
    end else begin
      r_ex_valid <= 1'b1;
      r_ex       <= w_dec_ctrl;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign imm_sel_o    = w_imm_sel;
  assign illegal_o    = w_illegal && id_valid_i;
  assign stall_o      = w_stall;
  assign flush_o      = w_flush;
  assign ex_valid_o   = r_ex_valid;
  assign ex_rd_o      = r_ex.rd;
  assign ex_reg_wr_o  = r_ex.reg_wr;
  assign ex_mem_rd_o  = r_ex.mem_rd;
  assign ex_mem_wr_o  = r_ex.mem_wr;
  assign ex_branch_o  = r_ex.branch;
  assign ex_jump_o    = r_ex.jump;
  assign ex_wb_sel_o  = r_ex.wb_sel;
  assign ex_alu_src_o = r_ex.alu_src;
  assign stall_cnt_o  = r_stall_cnt;

endmodule
